// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the program sequencer and the processor control FSM:
// field widths, opcode constants and the sequencer state encoding.
package instr_sequencer_pkg;

    localparam int FUNC_W  = 4;
    localparam int DATA_W  = 3;
    localparam int INSTR_W = FUNC_W + 2 * DATA_W;

    localparam logic [FUNC_W-1:0] OP_HALT = 4'b0000;
    localparam logic [FUNC_W-1:0] OP_LOAD = 4'b0001;
    localparam logic [FUNC_W-1:0] OP_MOVE = 4'b0010;
    localparam logic [FUNC_W-1:0] OP_ADD  = 4'b0011;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_HALT  = 3'd4
    } seq_state_e;

    // Opcode field of a packed {func, input1, input2} word.
    function automatic logic [FUNC_W-1:0] instr_func(input logic [INSTR_W-1:0] w);
        return w[INSTR_W-1 -: FUNC_W];
    endfunction

endpackage

// File: rtl/instr_sequencer_store.sv
// Instruction register file: one synchronous write port and one registered
// read port. The array itself is not reset, so contents survive rst_n.
module instr_store #(
    parameter int DEPTH = 8,
    parameter int W     = 10,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [W-1:0]  wr_data_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [W-1:0]  rd_data_o
);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] rd_data_q;

    // Storage array write port
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Registered read; a same-edge write to the same slot returns the old word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= {W{1'b0}};
        end else begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/instr_sequencer.sv
// Program sequencer: steps a pc through the instruction store and hands one
// {func, input1, input2} word at a time to the control FSM, waiting for done.
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int                DEPTH   = 8,
    parameter int                FUNC_W  = instr_sequencer_pkg::FUNC_W,
    parameter int                DATA_W  = instr_sequencer_pkg::DATA_W,
    parameter logic [FUNC_W-1:0] HALT_OP = OP_HALT,
    parameter int                AW      = $clog2(DEPTH),
    parameter int                IW      = FUNC_W + 2 * DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_en,
    input  logic [AW-1:0]     load_addr,
    input  logic [IW-1:0]     load_instr,
    input  logic              start,
    input  logic              done,
    output logic [FUNC_W-1:0] func,
    output logic [DATA_W-1:0] input1,
    output logic [DATA_W-1:0] input2,
    output logic              instr_valid,
    output logic              busy,
    output logic              halted,
    output logic [AW-1:0]     pc
);

    localparam logic [AW-1:0] PC_ZERO = {AW{1'b0}};
    localparam logic [AW-1:0] PC_LAST = AW'(DEPTH - 1);
    localparam logic [AW-1:0] PC_ONE  = AW'(1);

    seq_state_e        state_q, state_d;
    logic [AW-1:0]     pc_q, pc_d;
    logic [FUNC_W-1:0] func_q;
    logic [DATA_W-1:0] input1_q, input2_q;
    logic              instr_valid_q, busy_q, halted_q;
    logic              load_out_s;
    logic              store_we_s;
    logic [IW-1:0]     rd_data_s;

    assign store_we_s = load_en && ((state_q == ST_IDLE) || (state_q == ST_HALT));

    // The read address follows pc_d so the word for pc is ready during FETCH.
    instr_store #(
        .DEPTH (DEPTH),
        .W     (IW),
        .AW    (AW)
    ) u_store (
        .clk       (clk),
        .rst_n     (rst_n),
        .we_i      (store_we_s),
        .wr_addr_i (load_addr),
        .wr_data_i (load_instr),
        .rd_addr_i (pc_d),
        .rd_data_o (rd_data_s)
    );

    // Next-state, next-pc and output-load decision
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        load_out_s = 1'b0;
        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (start) begin
                    state_d = ST_FETCH;
                    pc_d    = PC_ZERO;
                end else begin
                    state_d = state_q;
                end
            end
            ST_FETCH: begin
                if (rd_data_s[IW-1 -: FUNC_W] == HALT_OP) begin
                    state_d = ST_HALT;
                end else begin
                    state_d    = ST_ISSUE;
                    load_out_s = 1'b1;
                end
            end
            ST_ISSUE, ST_WAIT: begin
                if (!done) begin
                    state_d = ST_WAIT;
                end else if (pc_q == PC_LAST) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_FETCH;
                    pc_d    = pc_q + PC_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                pc_d    = PC_ZERO;
            end
        endcase
    end

    // State, pc and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            pc_q          <= PC_ZERO;
            func_q        <= {FUNC_W{1'b0}};
            input1_q      <= {DATA_W{1'b0}};
            input2_q      <= {DATA_W{1'b0}};
            instr_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (load_out_s) begin
                func_q   <= rd_data_s[IW-1 -: FUNC_W];
                input1_q <= rd_data_s[2*DATA_W-1 -: DATA_W];
                input2_q <= rd_data_s[DATA_W-1:0];
            end
            instr_valid_q <= (state_d == ST_ISSUE);
            busy_q        <= (state_d == ST_FETCH) || (state_d == ST_ISSUE) ||
                             (state_d == ST_WAIT);
            halted_q      <= (state_d == ST_HALT);
        end
    end

    assign func        = func_q;
    assign input1      = input1_q;
    assign input2      = input2_q;
    assign instr_valid = instr_valid_q;
    assign busy        = busy_q;
    assign halted      = halted_q;
    assign pc          = pc_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: loads small programs, answers done
// with various delays, and checks issue timing, halting and reset behaviour.
module tb_instr_sequencer;

    localparam int AW = 3;
    localparam int IW = 10;

    logic          clk        = 1'b0;
    logic          rst_n      = 1'b0;
    logic          load_en    = 1'b0;
    logic [AW-1:0] load_addr  = 3'd0;
    logic [IW-1:0] load_instr = 10'd0;
    logic          start      = 1'b0;
    logic          done       = 1'b0;
    logic [3:0]    func;
    logic [2:0]    input1;
    logic [2:0]    input2;
    logic          instr_valid;
    logic          busy;
    logic          halted;
    logic [AW-1:0] pc;

    int checks = 0;
    int errors = 0;

    instr_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_en     (load_en),
        .load_addr   (load_addr),
        .load_instr  (load_instr),
        .start       (start),
        .done        (done),
        .func        (func),
        .input1      (input1),
        .input2      (input2),
        .instr_valid (instr_valid),
        .busy        (busy),
        .halted      (halted),
        .pc          (pc)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [AW-1:0] a, input logic [IW-1:0] w);
        load_en    = 1'b1;
        load_addr  = a;
        load_instr = w;
        tick();
        load_en    = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_done();
        done = 1'b1;
        tick();
        done = 1'b0;
    endtask

    task automatic chk_word(input string tag, input logic [IW-1:0] w);
        chk(tag, 32'({func, input1, input2}), 32'(w));
    endtask

    int nv;
    int first_c;
    int last_c;

    initial begin
        // ---- reset state
        repeat (3) tick();
        chk_word("rst_word", 10'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_pc", 32'(pc), 32'd0);
        #2 rst_n = 1'b1;
        tick();

        // ---- two LOADs then HALT, done 3 cycles after each issue
        load(3'd0, 10'b0001_000_011);
        load(3'd1, 10'b0001_001_101);
        load(3'd2, 10'b0000_000_000);
        pulse_start();
        chk("t1_fetch_busy", 32'(busy), 32'd1);
        chk("t1_fetch_valid", 32'(instr_valid), 32'd0);
        tick();
        chk("t1_i0_valid", 32'(instr_valid), 32'd1);
        chk_word("t1_i0_word", 10'b0001_000_011);
        chk("t1_i0_pc", 32'(pc), 32'd0);
        tick();
        chk("t1_wait_valid", 32'(instr_valid), 32'd0);
        chk_word("t1_wait_word", 10'b0001_000_011);
        tick();
        pulse_done();
        chk("t1_adv_pc", 32'(pc), 32'd1);
        chk("t1_adv_valid", 32'(instr_valid), 32'd0);
        tick();
        chk("t1_i1_valid", 32'(instr_valid), 32'd1);
        chk_word("t1_i1_word", 10'b0001_001_101);
        tick();
        tick();
        pulse_done();
        tick();
        chk("t1_halted", 32'(halted), 32'd1);
        chk("t1_halt_busy", 32'(busy), 32'd0);
        chk("t1_halt_pc", 32'(pc), 32'd2);
        chk_word("t1_halt_word", 10'b0001_001_101);
        nv = 0;
        for (int i = 0; i < 5; i++) begin
            if (instr_valid) nv++;
            tick();
        end
        chk("t1_no_third", 32'(nv), 32'd0);

        // ---- all slots ADD, done in the issue cycle
        for (int i = 0; i < 8; i++) load(3'(i), 10'b0011_000_001);
        pulse_start();
        nv = 0;
        first_c = -1;
        last_c = -1;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (instr_valid) begin
                nv++;
                if (first_c < 0) first_c = c;
                last_c = c;
            end
            done = instr_valid;
        end
        done = 1'b0;
        chk("t2_issues", 32'(nv), 32'd8);
        chk("t2_first", 32'(first_c), 32'd1);
        chk("t2_last", 32'(last_c), 32'd15);
        chk("t2_halted", 32'(halted), 32'd1);
        chk("t2_pc", 32'(pc), 32'd7);
        chk_word("t2_word", 10'b0011_000_001);

        // ---- load_en and start ignored while waiting
        load(3'd0, 10'b0010_010_110);
        load(3'd1, 10'b0000_000_000);
        pulse_start();
        tick();
        chk("t3_valid", 32'(instr_valid), 32'd1);
        tick();
        load_en    = 1'b1;
        load_addr  = 3'd0;
        load_instr = 10'b0011_111_111;
        start      = 1'b1;
        tick();
        load_en = 1'b0;
        start   = 1'b0;
        chk("t3_busy", 32'(busy), 32'd1);
        chk("t3_no_restart", 32'(instr_valid), 32'd0);
        chk("t3_pc", 32'(pc), 32'd0);
        chk_word("t3_stable0", 10'b0010_010_110);
        tick();
        chk_word("t3_stable1", 10'b0010_010_110);
        pulse_done();
        tick();
        chk("t3_halted", 32'(halted), 32'd1);
        chk("t3_halt_pc", 32'(pc), 32'd1);
        pulse_start();
        tick();
        chk("t3_rerun_valid", 32'(instr_valid), 32'd1);
        chk_word("t3_store_kept", 10'b0010_010_110);

        // ---- reset mid-WAIT at instruction 2, then rerun
        pulse_done();
        tick();
        load(3'd1, 10'b0011_010_100);
        load(3'd2, 10'b0000_000_000);
        pulse_start();
        tick();
        pulse_done();
        tick();
        chk("t4_i1_valid", 32'(instr_valid), 32'd1);
        chk_word("t4_i1_word", 10'b0011_010_100);
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk_word("t4_rst_word", 10'd0);
        chk("t4_rst_busy", 32'(busy), 32'd0);
        chk("t4_rst_halted", 32'(halted), 32'd0);
        chk("t4_rst_pc", 32'(pc), 32'd0);
        chk("t4_rst_valid", 32'(instr_valid), 32'd0);
        tick();
        #2 rst_n = 1'b1;
        pulse_done();
        chk("t5_idle_done_busy", 32'(busy), 32'd0);
        chk("t5_idle_done_pc", 32'(pc), 32'd0);
        pulse_start();
        tick();
        chk("t4_rerun_valid", 32'(instr_valid), 32'd1);
        chk_word("t4_rerun_w0", 10'b0010_010_110);
        pulse_done();
        tick();
        chk_word("t4_rerun_w1", 10'b0011_010_100);
        pulse_done();
        tick();
        chk("t4_halted", 32'(halted), 32'd1);
        chk("t4_halt_pc", 32'(pc), 32'd2);

        // ---- done ignored in HALT, restart from HALT
        pulse_done();
        chk("t5_halt_done_halted", 32'(halted), 32'd1);
        chk("t5_halt_done_pc", 32'(pc), 32'd2);
        pulse_start();
        chk("t5_restart_pc", 32'(pc), 32'd0);
        chk("t5_restart_busy", 32'(busy), 32'd1);
        tick();
        chk("t5_restart_valid", 32'(instr_valid), 32'd1);
        chk_word("t5_restart_word", 10'b0010_010_110);
        pulse_done();
        tick();
        pulse_done();
        tick();
        chk("t5_halted", 32'(halted), 32'd1);

        // ---- start with same-address load in IDLE reads the old HALT word
        load(3'd0, 10'b0000_000_000);
        rst_n = 1'b0;
        tick();
        #2 rst_n = 1'b1;
        start      = 1'b1;
        load_en    = 1'b1;
        load_addr  = 3'd0;
        load_instr = 10'b0001_011_111;
        tick();
        start   = 1'b0;
        load_en = 1'b0;
        chk("t6_fetch_busy", 32'(busy), 32'd1);
        chk("t6_fetch_valid", 32'(instr_valid), 32'd0);
        tick();
        chk("t6_halted", 32'(halted), 32'd1);
        chk("t6_no_issue", 32'(instr_valid), 32'd0);
        chk("t6_pc", 32'(pc), 32'd0);
        chk_word("t6_word", 10'd0);
        pulse_start();
        tick();
        chk("t6_new_valid", 32'(instr_valid), 32'd1);
        chk_word("t6_new_word", 10'b0001_011_111);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
